// File: rtl/defog_pipe_divider.sv
// -----------------------------------------------------------------------------
// defog_pipe_divider
//
// Fully pipelined restoring divider for the defog datapath. Each accepted
// operand pair produces floor(dividend / divisor), saturated to QUOT_W bits,
// together with the tag that entered with it. One result per cycle; a single
// global stall freezes the whole pipe whenever the output is held.
//
// Pipeline shape:
//   S0          input register (dividend, clamped divisor, zero flag, tag)
//   S1..SN      one quotient bit per stage, MSB first (N = DIVIDEND_W)
//   S(N+1)      output register with saturation and flags
//
// Ports:
//   clk        rising-edge clock
//   nrst       synchronous active-low reset (clears every valid bit)
//   in_valid   operands valid
//   in_ready   operands can be accepted this cycle (combinational, ~stall)
//   dividend   unsigned numerator, DIVIDEND_W bits
//   divisor    unsigned denominator, DIVISOR_W bits
//   in_tag     sideband carried alongside the operands
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   quotient   saturated floor quotient, QUOT_W bits
//   out_tag    in_tag of the same transaction
//   div_zero   effective divisor was zero
//   overflow   true quotient did not fit in QUOT_W bits (also on div_zero)
// -----------------------------------------------------------------------------
module defog_pipe_divider #(
   parameter int DIVIDEND_W = 12,
   parameter int DIVISOR_W  = 8,
   parameter int QUOT_W     = 8,
   parameter int MIN_DIV    = 0,
   parameter int TAG_W      = 1
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [QUOT_W-1:0]     quotient,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  div_zero,
   output logic                  overflow
);

   localparam int N  = DIVIDEND_W;
   localparam int RW = DIVISOR_W + 1;
   localparam logic [DIVISOR_W-1:0] MIN_DIV_V = DIVISOR_W'(MIN_DIV);

   // Global stall: nothing moves while a result sits unaccepted at the output.
   logic stall;

   // Effective divisor after the transmission-floor clamp.
   logic [DIVISOR_W-1:0] eff_div;

   // Per-stage state. Index 0 is S0, index k is iteration stage Sk.
   // dq holds the not-yet-consumed dividend bits in its upper part and the
   // quotient bits produced so far in its lower part; every stage shifts it
   // left by one, so after N stages it is exactly the internal quotient.
   logic [N:0]                      vld_q, vld_d;
   logic [N:0]                      zero_q, zero_d;
   logic [N:0][TAG_W-1:0]           tag_q, tag_d;
   logic [N:0][N-1:0]               dq_q, dq_d;
   logic [N-1:0][DIVISOR_W-1:0]     dsr_q, dsr_d;
   logic [N-1:1][RW-1:0]            rem_q, rem_d;

   // Combinational helpers for the iteration stages.
   logic [N:1][RW-1:0]              rin_v;
   logic [RW:0]                     step_v;

   // Registered outputs.
   logic                            out_valid_q, out_valid_d;
   logic [QUOT_W-1:0]               quotient_q, quotient_d;
   logic [TAG_W-1:0]                out_tag_q, out_tag_d;
   logic                            div_zero_q, div_zero_d;
   logic                            overflow_q, overflow_d;

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor when it fits. Returns {qbit, new_rem}.
   // The remainder never reaches d, so the difference always fits in RW bits
   // and can be taken modulo 2^RW.
   function automatic logic [RW:0] div_step(
      input logic [RW-1:0]        rem,
      input logic                 bit_in,
      input logic [DIVISOR_W-1:0] d
   );
      logic [RW:0]   trial;
      logic [RW-1:0] diff;
      trial = {rem, bit_in};
      diff  = trial[RW-1:0] - {1'b0, d};
      if (trial >= {2'b00, d}) begin
         div_step = {1'b1, diff};
      end else begin
         div_step = {1'b0, trial[RW-1:0]};
      end
   endfunction

   // Divisor floor. With no floor configured the divisor passes straight
   // through, which also avoids a comparison against zero that is always false.
   generate
      if (MIN_DIV > 0) begin : g_clamp
         assign eff_div = (divisor < MIN_DIV_V) ? MIN_DIV_V : divisor;
      end else begin : g_no_clamp
         assign eff_div = divisor;
      end
   endgenerate

   // Flow control: the pipe only stalls when the output holds a result that
   // downstream refuses, and input acceptance follows directly from that.
   always_comb begin
      stall    = out_valid_q & ~out_ready;
      in_ready = ~stall;
   end

   // Next-state for S0 and the iteration stages. Every stage reads only the
   // registered contents of the stage before it, so the critical path is a
   // single compare/subtract of DIVISOR_W+2 bits.
   always_comb begin
      vld_d  = '0;
      zero_d = '0;
      tag_d  = '0;
      dq_d   = '0;
      dsr_d  = '0;
      rem_d  = '0;
      rin_v  = '0;
      step_v = '0;

      vld_d[0]  = in_valid & in_ready;
      zero_d[0] = (eff_div == '0);
      tag_d[0]  = in_tag;
      dq_d[0]   = dividend;
      dsr_d[0]  = eff_div;

      // The first iteration starts from an empty partial remainder.
      rin_v[1] = '0;
      for (int k = 2; k <= N; k++) begin
         rin_v[k] = rem_q[k-1];
      end

      for (int k = 1; k <= N; k++) begin
         vld_d[k]  = vld_q[k-1];
         zero_d[k] = zero_q[k-1];
         tag_d[k]  = tag_q[k-1];
      end

      for (int k = 1; k <= N - 1; k++) begin
         step_v   = div_step(rin_v[k], dq_q[k-1][N-1], dsr_q[k-1]);
         dq_d[k]  = {dq_q[k-1][N-2:0], step_v[RW]};
         rem_d[k] = step_v[RW-1:0];
         dsr_d[k] = dsr_q[k-1];
      end

      // The last iteration only contributes the LSB of the quotient; its
      // remainder and divisor are not needed any further.
      step_v  = div_step(rin_v[N], dq_q[N-1][N-1], dsr_q[N-1]);
      dq_d[N] = {dq_q[N-1][N-2:0], step_v[RW]};
   end

   // Output stage: saturate and flag. Invalid slots drive all-zero outputs so
   // downstream never sees stale data alongside out_valid = 0.
   always_comb begin
      out_valid_d = vld_q[N];
      quotient_d  = '0;
      out_tag_d   = '0;
      div_zero_d  = 1'b0;
      overflow_d  = 1'b0;
      if (vld_q[N]) begin
         out_tag_d = tag_q[N];
         if (zero_q[N]) begin
            quotient_d = '1;
            div_zero_d = 1'b1;
            overflow_d = 1'b1;
         end else if (|(dq_q[N] >> QUOT_W)) begin
            quotient_d = '1;
            overflow_d = 1'b1;
         end else begin
            quotient_d = dq_q[N][QUOT_W-1:0];
         end
      end
   end

   // All pipeline state. Reset wins over stall so in-flight work is always
   // discarded; otherwise the whole pipe advances together or not at all,
   // which keeps bubbles in place and preserves ordering.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         vld_q       <= '0;
         zero_q      <= '0;
         tag_q       <= '0;
         dq_q        <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         out_tag_q   <= '0;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (!stall) begin
         vld_q       <= vld_d;
         zero_q      <= zero_d;
         tag_q       <= tag_d;
         dq_q        <= dq_d;
         dsr_q       <= dsr_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         quotient_q  <= quotient_d;
         out_tag_q   <= out_tag_d;
         div_zero_q  <= div_zero_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign quotient  = quotient_q;
   assign out_tag   = out_tag_q;
   assign div_zero  = div_zero_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_defog_pipe_divider.sv
// -----------------------------------------------------------------------------
// tb_defog_pipe_divider
//
// Directed and randomized checks of defog_pipe_divider. The main instance
// (default widths, 8-bit tag) is compared cycle by cycle against a queue of
// expected results computed with plain integer division. Two extra instances
// cover the divisor floor and a wider parameter set.
// -----------------------------------------------------------------------------
module tb_defog_pipe_divider;

   localparam int DW = 12;
   localparam int SW = 8;
   localparam int QW = 8;
   localparam int TW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance signals
   logic          nrst;
   logic          in_valid, in_ready, out_valid, out_ready, div_zero, overflow;
   logic [DW-1:0] dividend;
   logic [SW-1:0] divisor;
   logic [TW-1:0] in_tag, out_tag;
   logic [QW-1:0] quotient;

   // Clamp instance signals (MIN_DIV = 26)
   logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_div_zero, c_overflow;
   logic [11:0]   c_dividend;
   logic [7:0]    c_divisor, c_quotient;
   logic [0:0]    c_in_tag, c_out_tag;

   // Wide instance signals (16 / 10 / 12)
   logic          w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_div_zero, w_overflow;
   logic [15:0]   w_dividend;
   logic [9:0]    w_divisor;
   logic [11:0]   w_quotient;
   logic [0:0]    w_in_tag, w_out_tag;

   defog_pipe_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .QUOT_W(QW), .MIN_DIV(0), .TAG_W(TW)) dut (
      .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
      .out_tag(out_tag), .div_zero(div_zero), .overflow(overflow)
   );

   defog_pipe_divider #(.DIVIDEND_W(12), .DIVISOR_W(8), .QUOT_W(8), .MIN_DIV(26), .TAG_W(1)) dut_clamp (
      .clk(clk), .nrst(nrst), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .dividend(c_dividend), .divisor(c_divisor), .in_tag(c_in_tag),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .quotient(c_quotient),
      .out_tag(c_out_tag), .div_zero(c_div_zero), .overflow(c_overflow)
   );

   defog_pipe_divider #(.DIVIDEND_W(16), .DIVISOR_W(10), .QUOT_W(12), .MIN_DIV(0), .TAG_W(1)) dut_wide (
      .clk(clk), .nrst(nrst), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .dividend(w_dividend), .divisor(w_divisor), .in_tag(w_in_tag),
      .out_valid(w_out_valid), .out_ready(w_out_ready), .quotient(w_quotient),
      .out_tag(w_out_tag), .div_zero(w_div_zero), .overflow(w_overflow)
   );

   typedef struct packed {
      logic [QW-1:0] q;
      logic          dz;
      logic          ov;
      logic [TW-1:0] tag;
      logic [31:0]   acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks    = 0;
   int   errors    = 0;
   int   edge_cnt  = 0;
   int   delivered = 0;
   bit   check_lat = 1'b0;
   bit   prev_stall = 1'b0;
   logic [QW+TW+1:0] snap;

   // Single comparison point: every check in the bench goes through here.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: saturated floor division from the arithmetic definition.
   function automatic exp_t model(input int dvd, input int dsr, input int tag, input int acc);
      exp_t   e;
      longint qv;
      e.tag = TW'(tag);
      e.acc = acc;
      e.q   = '0;
      e.dz  = 1'b0;
      e.ov  = 1'b0;
      if (dsr == 0) begin
         e.q = '1; e.dz = 1'b1; e.ov = 1'b1;
      end else begin
         qv = longint'(dvd) / longint'(dsr);
         if (qv > (64'd1 << QW) - 1) begin
            e.q = '1; e.ov = 1'b1;
         end else begin
            e.q = QW'(qv);
         end
      end
      return e;
   endfunction

   task automatic applyStimulus(input logic v, input int dvd, input int dsr, input int tag, input logic ordy);
      in_valid  = v;
      dividend  = DW'(dvd);
      divisor   = SW'(dsr);
      in_tag    = TW'(tag);
      out_ready = ordy;
   endtask

   // Called just before a rising edge: compares visible outputs against the
   // head of the expected queue, then updates the model for that edge.
   task automatic checkOutput();
      logic [QW+TW+1:0] cur;
      exp_t e;
      cur = {quotient, out_tag, div_zero, overflow};
      check("in_ready", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (prev_stall) check("stall_hold", {out_valid, cur}, {1'b1, snap});
      if (out_valid !== 1'b1) begin
         check("idle_outputs_zero", {out_valid, cur}, '0);
      end else if (exp_q.size() == 0) begin
         check("unexpected_output", {63'd0, out_valid}, 64'd0);
      end else begin
         e = exp_q[0];
         check("quotient", quotient, e.q);
         check("out_tag", out_tag, e.tag);
         check("div_zero", div_zero, e.dz);
         check("overflow", overflow, e.ov);
         if (out_ready && nrst) begin
            if (check_lat) check("latency", edge_cnt - e.acc + 1, DW + 2);
            void'(exp_q.pop_front());
            delivered++;
         end
      end
      prev_stall = out_valid && !out_ready && nrst;
      snap = cur;
      if (!nrst) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(dividend, divisor, in_tag, edge_cnt + 1));
   endtask

   task automatic cycle(input logic v, input int dvd, input int dsr, input int tag, input logic ordy, output bit accepted);
      applyStimulus(v, dvd, dsr, tag, ordy);
      #1;
      accepted = in_valid && in_ready && nrst;
      checkOutput();
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
   endtask

   task automatic drain(input int budget, input bit rnd_ready);
      bit acc;
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && out_valid === 1'b0) break;
         cycle(1'b0, 0, 1, 0, rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   task automatic runDirected(input int dvd, input int dsr, input int tag);
      bit acc;
      check_lat = 1'b1;
      cycle(1'b1, dvd, dsr, tag, 1'b1, acc);
      check("directed_accepted", {63'd0, acc}, 64'd1);
      drain(40, 1'b0);
      check_lat = 1'b0;
   endtask

   task automatic runClamp(input int dvd, input int dsr, input int eq, input logic edz, input logic eov);
      int lat = 0;
      c_in_valid = 1'b1; c_dividend = 12'(dvd); c_divisor = 8'(dsr);
      @(posedge clk); @(negedge clk);
      c_in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (c_out_valid === 1'b1) begin lat = i; break; end
         @(posedge clk); @(negedge clk);
      end
      check("clamp_latency", lat, 14);
      check("clamp_quotient", c_quotient, eq);
      check("clamp_flags", {c_div_zero, c_overflow}, {edz, eov});
      @(posedge clk); @(negedge clk);
   endtask

   task automatic runWide(input int dvd, input int dsr, input int eq, input logic eov);
      int lat = 0;
      w_in_valid = 1'b1; w_dividend = 16'(dvd); w_divisor = 10'(dsr);
      @(posedge clk); @(negedge clk);
      w_in_valid = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (w_out_valid === 1'b1) begin lat = i; break; end
         @(posedge clk); @(negedge clk);
      end
      check("wide_latency", lat, 18);
      check("wide_quotient", w_quotient, eq);
      check("wide_flags", {w_div_zero, w_overflow}, {1'b0, eov});
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      int idx, budget, cur_dvd, cur_dsr, d0;

      nrst = 1'b0;
      applyStimulus(1'b0, 0, 1, 0, 1'b1);
      c_in_valid = 1'b0; c_dividend = '0; c_divisor = 8'd1; c_in_tag = '0; c_out_ready = 1'b1;
      w_in_valid = 1'b0; w_dividend = '0; w_divisor = 10'd1; w_in_tag = '0; w_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // Reset state (still in reset)
      cycle(1'b0, 0, 1, 0, 1'b1, acc);
      nrst = 1'b1;
      $display("[TB] reset state checked, starting directed cases");

      // Basic results, saturation and divide-by-zero on the main instance
      runDirected(4095, 255, 1);
      runDirected(1000, 200, 2);
      runDirected(4095, 16, 3);
      runDirected(4095, 15, 4);
      runDirected(77, 0, 5);
      runDirected(2600, 10, 6);

      // Divisor floor and the wider build
      runClamp(2600, 10, 100, 1'b0, 1'b0);
      runClamp(77, 0, 2, 1'b0, 1'b0);
      runWide(65535, 1023, 64, 1'b0);
      runWide(65535, 8, 4095, 1'b1);

      // Back-to-back random stream with random backpressure
      $display("[TB] random stream");
      d0 = delivered;
      idx = 0; budget = 0;
      cur_dvd = $urandom_range(0, 4095);
      cur_dsr = $urandom_range(0, 255);
      while (idx < 200 && budget < 3000) begin
         cycle(1'b1, cur_dvd, cur_dsr, idx, 1'($urandom_range(0, 1)), acc);
         if (acc) begin
            idx++;
            cur_dvd = $urandom_range(0, 4095);
            cur_dsr = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
         end
         budget++;
      end
      check("stream_accepted", idx, 200);
      drain(2000, 1'b1);
      check("stream_delivered", delivered - d0, 200);

      // Reset with five transactions in flight, plus one offered during reset
      $display("[TB] reset mid-stream");
      for (int i = 0; i < 5; i++) cycle(1'b1, 1000 + i, 7, 10 + i, 1'b1, acc);
      nrst = 1'b0;
      cycle(1'b1, 999, 1, 77, 1'b1, acc);
      nrst = 1'b1;
      for (int i = 0; i < 20; i++) cycle(1'b0, 0, 1, 0, 1'b1, acc);
      runDirected(300, 3, 9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
